demux_bit_sequencer: RTL and testbench

- Upstream driver for the 1-to-8 demultiplexer stage.
- Accepts an 8-bit word over a valid/ready handshake and serialises it one bit per clock onto the demux data line `in`.
- For each bit it drives the matching select code on s2,s1,s0, so that bit k of the word lands on demux output dk.
- Provides a strobe, a completion pulse and a count of completed words for the downstream consumer.

---
 rtl/demux_bit_sequencer.sv | 104 ++++++++++
 tb/tb_demux_bit_sequencer.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/demux_bit_sequencer.sv
// Serialises an 8-bit word onto a 1-to-8 demux: one bit per clock on `in`, with the
// matching select code on s2..s0, so bit k of the word always lands on demux output dk.
module demux_bit_sequencer #(
  parameter int unsigned GAP        = 1,
  parameter bit          DESCENDING = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  output logic       data_ready,
  output logic       in,
  output logic       s0,
  output logic       s1,
  output logic       s2,
  output logic       strobe,
  output logic       busy,
  output logic       done,
  output logic [7:0] word_cnt
);

  typedef enum logic [1:0] {StIdle, StShift, StGap} state_e;

  localparam logic [3:0] GapCycles = 4'(GAP);
  localparam logic [2:0] FirstChan = DESCENDING ? 3'd7 : 3'd0;
  localparam logic [2:0] LastChan  = DESCENDING ? 3'd0 : 3'd7;

  state_e     state_q;
  logic [7:0] word_q;
  logic [2:0] chan_q;
  logic [2:0] sel_q;
  logic [3:0] gap_q;
  logic [2:0] chan_nxt;

  assign chan_nxt     = DESCENDING ? chan_q - 3'd1 : chan_q + 3'd1;
  assign {s2, s1, s0} = sel_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      word_q     <= '0;
      chan_q     <= '0;
      sel_q      <= '0;
      gap_q      <= '0;
      data_ready <= 1'b0;
      in         <= 1'b0;
      strobe     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      word_cnt   <= '0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          data_ready <= 1'b1;
          if (data_valid && data_ready) begin
            // The word is latched here so later data_in changes cannot reach the line.
            word_q     <= data_in;
            chan_q     <= FirstChan;
            sel_q      <= FirstChan;
            in         <= data_in[FirstChan];
            strobe     <= 1'b1;
            busy       <= 1'b1;
            data_ready <= 1'b0;
            state_q    <= StShift;
          end
        end
        StShift: begin
          if (chan_q == LastChan) begin
            // Park the line and select at zero so every demux output stays low.
            strobe   <= 1'b0;
            in       <= 1'b0;
            sel_q    <= '0;
            done     <= 1'b1;
            word_cnt <= word_cnt + 8'd1;
            if (GapCycles == 4'd0) begin
              state_q    <= StIdle;
              data_ready <= 1'b1;
              busy       <= 1'b0;
            end else begin
              state_q <= StGap;
              gap_q   <= 4'd1;
            end
          end else begin
            chan_q <= chan_nxt;
            sel_q  <= chan_nxt;
            in     <= word_q[chan_nxt];
          end
        end
        StGap: begin
          if (gap_q == GapCycles) begin
            state_q    <= StIdle;
            data_ready <= 1'b1;
            busy       <= 1'b0;
          end else begin
            gap_q <= gap_q + 4'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_demux_bit_sequencer.sv
// Bench for demux_bit_sequencer: three configurations checked every cycle against a
// schedule-based model, plus directed checks with hand-computed expectations.
module tb_demux_bit_sequencer;

  typedef struct packed {
    logic       ready;
    logic       in;
    logic [2:0] sel;
    logic       strobe;
    logic       busy;
    logic       done;
  } frame_t;

  localparam int GAPS  [3] = '{1, 3, 0};
  localparam int DESCS [3] = '{0, 1, 0};

  logic       clk;
  logic       rst_n;
  logic [2:0] dv;
  logic [7:0] din [3];
  logic [2:0] o_ready, o_in, o_s0, o_s1, o_s2, o_strobe, o_busy, o_done;
  logic [7:0] o_cnt [3];

  int checks = 0;
  int errors = 0;

  frame_t     mq [3][$];
  frame_t     exp_f [3];
  logic [7:0] exp_cnt [3];

  demux_bit_sequencer #(.GAP(1), .DESCENDING(1'b0)) u_asc (
    .clk(clk), .rst_n(rst_n), .data_in(din[0]), .data_valid(dv[0]), .data_ready(o_ready[0]),
    .in(o_in[0]), .s0(o_s0[0]), .s1(o_s1[0]), .s2(o_s2[0]), .strobe(o_strobe[0]),
    .busy(o_busy[0]), .done(o_done[0]), .word_cnt(o_cnt[0])
  );

  demux_bit_sequencer #(.GAP(3), .DESCENDING(1'b1)) u_desc (
    .clk(clk), .rst_n(rst_n), .data_in(din[1]), .data_valid(dv[1]), .data_ready(o_ready[1]),
    .in(o_in[1]), .s0(o_s0[1]), .s1(o_s1[1]), .s2(o_s2[1]), .strobe(o_strobe[1]),
    .busy(o_busy[1]), .done(o_done[1]), .word_cnt(o_cnt[1])
  );

  demux_bit_sequencer #(.GAP(0), .DESCENDING(1'b0)) u_zero (
    .clk(clk), .rst_n(rst_n), .data_in(din[2]), .data_valid(dv[2]), .data_ready(o_ready[2]),
    .in(o_in[2]), .s0(o_s0[2]), .s1(o_s1[2]), .s2(o_s2[2]), .strobe(o_strobe[2]),
    .busy(o_busy[2]), .done(o_done[2]), .word_cnt(o_cnt[2])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic frame_t dut_frame(input int i);
    frame_t f;
    f.ready  = o_ready[i];
    f.in     = o_in[i];
    f.sel    = {o_s2[i], o_s1[i], o_s0[i]};
    f.strobe = o_strobe[i];
    f.busy   = o_busy[i];
    f.done   = o_done[i];
    return f;
  endfunction

  // An accepted word fixes the next 9+GAP cycles of output outright.
  function automatic void push_word(input int i, input logic [7:0] w);
    frame_t f;
    int     g = GAPS[i];
    for (int k = 0; k < 8; k++) begin
      int c = (DESCS[i] != 0) ? 7 - k : k;
      f        = '0;
      f.in     = w[c];
      f.sel    = c[2:0];
      f.strobe = 1'b1;
      f.busy   = 1'b1;
      mq[i].push_back(f);
    end
    f       = '0;
    f.done  = 1'b1;
    f.busy  = (g > 0);
    f.ready = (g == 0);
    mq[i].push_back(f);
    for (int j = 1; j <= g; j++) begin
      f       = '0;
      f.busy  = (j < g);
      f.ready = (j == g);
      mq[i].push_back(f);
    end
  endfunction

  function automatic void model_step(input int i);
    frame_t f;
    if (!rst_n) begin
      mq[i].delete();
      exp_f[i]   = '0;
      exp_cnt[i] = '0;
    end else begin
      if (dv[i] && exp_f[i].ready) push_word(i, din[i]);
      if (mq[i].size() > 0) begin
        f = mq[i].pop_front();
        if (f.done) exp_cnt[i] = exp_cnt[i] + 8'd1;
      end else begin
        f       = '0;
        f.ready = 1'b1;
      end
      exp_f[i] = f;
    end
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) model_step(i);
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("frame[%0d]", i), 32'(dut_frame(i)), 32'(exp_f[i]));
      check($sformatf("word_cnt[%0d]", i), 32'(o_cnt[i]), 32'(exp_cnt[i]));
    end
  end

  task automatic wait_ready(input int i);
    int n = 0;
    @(negedge clk);
    while (!o_ready[i] && n < 100) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("ready_timeout[%0d]", i), 32'(o_ready[i]), 32'd1);
  endtask

  // Returns at E0+#1 with data_valid dropped.
  task automatic send(input int i, input logic [7:0] w);
    wait_ready(i);
    din[i] = w;
    dv[i]  = 1'b1;
    @(posedge clk);
    #1;
    dv[i] = 1'b0;
  endtask

  task automatic collect(input int i, output logic [7:0] s_in, output logic [23:0] s_sel,
                         output int strobes, output int d0, output int dother);
    s_in = '0; s_sel = '0; strobes = 0; d0 = 0; dother = 0;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      s_in    = {s_in[6:0], o_in[i]};
      s_sel   = {s_sel[20:0], o_s2[i], o_s1[i], o_s0[i]};
      strobes += int'(o_strobe[i]);
      if (o_in[i]) begin
        if ({o_s2[i], o_s1[i], o_s0[i]} == 3'd0) d0++;
        else dother++;
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  s_in;
    logic [23:0] s_sel;
    int          nstr, d0, dother;

    rst_n = 1'b1;
    dv    = '0;
    for (int i = 0; i < 3; i++) din[i] = '0;
    #2 rst_n = 1'b0;

    // Reset then idle
    repeat (3) @(negedge clk);
    check("reset_frame", 32'(dut_frame(0)), 32'd0);
    check("reset_cnt", 32'(o_cnt[0]), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_release", 32'(o_ready[0]), 32'd1);
    check("strobe_after_release", 32'(o_strobe[0]), 32'd0);

    // Ascending A5, GAP=1
    send(0, 8'hA5);
    collect(0, s_in, s_sel, nstr, d0, dother);
    check("asc_bits", 32'(s_in), 32'hA5);
    check("asc_sel", 32'(s_sel), 32'(24'o01234567));
    check("asc_strobes", 32'(nstr), 32'd8);
    @(posedge clk); #1;
    check("asc_done_e8", 32'(o_done[0]), 32'd1);
    check("asc_ready_e8", 32'(o_ready[0]), 32'd0);
    @(posedge clk); #1;
    check("asc_done_e9", 32'(o_done[0]), 32'd0);
    check("asc_ready_e9", 32'(o_ready[0]), 32'd1);
    check("asc_cnt", 32'(o_cnt[0]), 32'd1);

    // Descending 01, GAP=3: only d0 ever goes high, on the last strobe cycle
    send(1, 8'h01);
    collect(1, s_in, s_sel, nstr, d0, dother);
    check("desc_bits", 32'(s_in), 32'h01);
    check("desc_sel", 32'(s_sel), 32'(24'o76543210));
    check("desc_d0_hits", 32'(d0), 32'd1);
    check("desc_other_hits", 32'(dother), 32'd0);
    repeat (4) @(posedge clk);
    #1;
    check("desc_ready_e11", 32'(o_ready[1]), 32'd1);

    // Back-to-back with GAP=0
    wait_ready(2);
    din[2] = 8'hFF;
    dv[2]  = 1'b1;
    @(posedge clk); #1;
    din[2] = 8'h00;
    collect(2, s_in, s_sel, nstr, d0, dother);
    check("b2b_first", 32'(s_in), 32'hFF);
    @(posedge clk); #1;
    check("b2b_done_e8", 32'(o_done[2]), 32'd1);
    check("b2b_ready_e8", 32'(o_ready[2]), 32'd1);
    @(posedge clk); #1;
    dv[2] = 1'b0;
    check("b2b_accept_e9", 32'(o_strobe[2]), 32'd1);
    collect(2, s_in, s_sel, nstr, d0, dother);
    check("b2b_second", 32'(s_in), 32'h00);
    check("b2b_second_sel", 32'(s_sel), 32'(24'o01234567));
    @(posedge clk); #1;
    check("b2b_cnt", 32'(o_cnt[2]), 32'd2);

    // Mid-word reset at bit 4 of 3C
    send(0, 8'h3C);
    repeat (4) @(posedge clk);
    #1;
    check("mid_sel4", 32'({o_s2[0], o_s1[0], o_s0[0]}), 32'd4);
    check("mid_in4", 32'(o_in[0]), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("mid_reset_frame", 32'(dut_frame(0)), 32'd0);
    check("mid_reset_cnt", 32'(o_cnt[0]), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send(0, 8'h5A);
    collect(0, s_in, s_sel, nstr, d0, dother);
    check("after_reset_bits", 32'(s_in), 32'h5A);
    @(posedge clk); #1;
    check("after_reset_cnt", 32'(o_cnt[0]), 32'd1);

    // Wrap and hold on GAP=0; data_in changes while the first word is in flight
    send(2, 8'h96);
    din[2] = 8'h0F;
    collect(2, s_in, s_sel, nstr, d0, dother);
    check("hold_bits", 32'(s_in), 32'h69);
    for (int k = 1; k < 256; k++) send(2, 8'(k));
    check("wrap_cnt_255", 32'(o_cnt[2]), 32'd255);
    repeat (8) @(posedge clk);
    #1;
    check("wrap_done", 32'(o_done[2]), 32'd1);
    check("wrap_cnt_0", 32'(o_cnt[2]), 32'd0);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
